// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and a variable-latency memory (slave).
// The master holds the request and its payload until the memory returns mem_done.
interface mem_stage_if #(
  parameter int DW = 16
);
  logic          mem_req;
  logic          mem_wr;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_done,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_done,
    output mem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: turns execute results into data-memory accesses, stalls execute while an
// access is outstanding, and registers one writeback result per consumed instruction.
module mem_stage #(
  parameter int DW       = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_aluout,
  input  logic [DW-1:0] ex_wdata,
  input  logic          ex_memrd,
  input  logic          ex_memwr,
  input  logic [2:0]    ex_wbreg,
  input  logic          ex_regwr,
  output logic          stall_ex,
  mem_stage_if.master   mem,
  output logic          wb_valid,
  output logic [DW-1:0] wb_data,
  output logic [2:0]    wb_reg,
  output logic          wb_regwr,
  output logic          wb_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          req_q, req_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          load_q, load_d;
  logic [2:0]    reg_q, reg_d;
  logic          regwr_q, regwr_d;

  logic          wb_valid_q, wb_valid_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [2:0]    wb_reg_q, wb_reg_d;
  logic          wb_regwr_q, wb_regwr_d;
  logic          wb_err_q, wb_err_d;

  logic          consume;
  logic          is_memop;
  logic          bad_op;

  // Decode of the instruction offered by execute
  always_comb begin
    stall_ex = (state_q == BUSY);
    consume  = ex_valid && !stall_ex;
    is_memop = ex_memrd || ex_memwr;
    bad_op   = is_memop && ((ex_memrd && ex_memwr) || ex_aluout[0]);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    load_d     = load_q;
    reg_d      = reg_q;
    regwr_d    = regwr_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_reg_d   = wb_reg_q;
    wb_regwr_d = 1'b0;
    wb_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (consume) begin
          if (!is_memop) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ex_aluout;
            wb_reg_d   = ex_wbreg;
            wb_regwr_d = ex_regwr;
          end else if (bad_op) begin
            // Illegal or misaligned: answer immediately, never touch memory
            wb_valid_d = 1'b1;
            wb_data_d  = ex_aluout;
            wb_reg_d   = ex_wbreg;
            wb_err_d   = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 8'd0;
            req_d   = 1'b1;
            wr_d    = ex_memwr;
            addr_d  = ex_aluout;
            wdata_d = ex_wdata;
            load_d  = ex_memrd;
            reg_d   = ex_wbreg;
            regwr_d = ex_regwr;
          end
        end
      end

      BUSY: begin
        if (mem.mem_done) begin
          // Completion takes priority over a timeout in the same cycle
          state_d    = IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = load_q ? mem.mem_rdata : addr_q;
          wb_reg_d   = reg_q;
          wb_regwr_d = regwr_q && load_q;
        end else if (cnt_q == LAST_WAIT) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = addr_q;
          wb_reg_d   = reg_q;
          wb_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Async reset drops mem_req and every output at once, even mid-access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      req_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      load_q     <= 1'b0;
      reg_q      <= 3'd0;
      regwr_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_reg_q   <= 3'd0;
      wb_regwr_q <= 1'b0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      load_q     <= load_d;
      reg_q      <= reg_d;
      regwr_q    <= regwr_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_reg_q   <= wb_reg_d;
      wb_regwr_q <= wb_regwr_d;
      wb_err_q   <= wb_err_d;
    end
  end

  always_comb begin
    mem.mem_req   = req_q;
    mem.mem_wr    = wr_q;
    mem.mem_addr  = addr_q;
    mem.mem_wdata = wdata_q;
    wb_valid      = wb_valid_q;
    wb_data       = wb_data_q;
    wb_reg        = wb_reg_q;
    wb_regwr      = wb_regwr_q;
    wb_err        = wb_err_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, load/store handshakes, error responses,
// timeout, done-vs-timeout priority and asynchronous reset in the middle of an access.
module tb_mem_stage;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 15;

  logic          clk;
  logic          rst;
  logic          ex_valid;
  logic [DW-1:0] ex_aluout;
  logic [DW-1:0] ex_wdata;
  logic          ex_memrd;
  logic          ex_memwr;
  logic [2:0]    ex_wbreg;
  logic          ex_regwr;
  logic          stall_ex;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [2:0]    wb_reg;
  logic          wb_regwr;
  logic          wb_err;

  int total = 0;
  int bad   = 0;

  mem_stage_if #(.DW(DW)) mem_bus ();

  mem_stage #(.DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .ex_aluout(ex_aluout),
    .ex_wdata (ex_wdata),
    .ex_memrd (ex_memrd),
    .ex_memwr (ex_memwr),
    .ex_wbreg (ex_wbreg),
    .ex_regwr (ex_regwr),
    .stall_ex (stall_ex),
    .mem      (mem_bus.master),
    .wb_valid (wb_valid),
    .wb_data  (wb_data),
    .wb_reg   (wb_reg),
    .wb_regwr (wb_regwr),
    .wb_err   (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                          input logic rd, input logic wr, input logic [2:0] r, input logic rw);
    ex_valid  = v;
    ex_aluout = a;
    ex_wdata  = wd;
    ex_memrd  = rd;
    ex_memwr  = wr;
    ex_wbreg  = r;
    ex_regwr  = rw;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    mem_bus.mem_done  = 1'b0;
    mem_bus.mem_rdata = '0;
    repeat (2) tick();
    total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_bus.mem_req); end
    total++; if (stall_ex !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_ex); end
    total++; if ({wb_valid, wb_data, wb_reg, wb_regwr, wb_err} !== '0) begin bad++; $display("FAIL reset_wb got=%b/%h/%0d/%b/%b exp=all zero", wb_valid, wb_data, wb_reg, wb_regwr, wb_err); end
    total++; if ({mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_wdata} !== '0) begin bad++; $display("FAIL reset_bus got=%b/%h/%h exp=all zero", mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_nonmem();
    drive_ex(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 3'd3, 1'b1);
    total++; if (stall_ex !== 1'b0) begin bad++; $display("FAIL nonmem_stall got=%b exp=0", stall_ex); end
    tick();
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    total++; if (wb_valid !== 1'b1 || wb_data !== 16'h1234) begin bad++; $display("FAIL nonmem_wb got=%b/%h exp=1/1234", wb_valid, wb_data); end
    total++; if (wb_reg !== 3'd3 || wb_regwr !== 1'b1 || wb_err !== 1'b0) begin bad++; $display("FAIL nonmem_ctl got=%0d/%b/%b exp=3/1/0", wb_reg, wb_regwr, wb_err); end
    total++; if (mem_bus.mem_req !== 1'b0 || stall_ex !== 1'b0) begin bad++; $display("FAIL nonmem_noreq got=%b/%b exp=0/0", mem_bus.mem_req, stall_ex); end
    tick();
    total++; if (wb_valid !== 1'b0 || wb_data !== 16'h1234 || wb_reg !== 3'd3) begin bad++; $display("FAIL nonmem_hold got=%b/%h/%0d exp=0/1234/3", wb_valid, wb_data, wb_reg); end
  endtask

  task automatic test_load();
    int req_cycles = 0;
    drive_ex(1'b1, 16'h0040, 16'h0000, 1'b1, 1'b0, 3'd5, 1'b1);
    tick();
    // Execute now offers a different instruction; it must stay unconsumed while stalled
    drive_ex(1'b1, 16'h7777, 16'h0000, 1'b0, 1'b0, 3'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (mem_bus.mem_req === 1'b1) req_cycles++;
      total++; if (stall_ex !== 1'b1 || mem_bus.mem_addr !== 16'h0040 || mem_bus.mem_wr !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL load_busy%0d got=stall %b addr %h wr %b wbv %b exp=1/0040/0/0", i, stall_ex, mem_bus.mem_addr, mem_bus.mem_wr, wb_valid); end
      if (i == 2) begin
        mem_bus.mem_done  = 1'b1;
        mem_bus.mem_rdata = 16'hBEEF;
      end
      tick();
    end
    mem_bus.mem_done  = 1'b0;
    mem_bus.mem_rdata = 16'h0000;
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    total++; if (req_cycles != 3 || mem_bus.mem_req !== 1'b0 || stall_ex !== 1'b0) begin bad++; $display("FAIL load_req got=%0d cycles req %b stall %b exp=3/0/0", req_cycles, mem_bus.mem_req, stall_ex); end
    total++; if (wb_valid !== 1'b1 || wb_data !== 16'hBEEF || wb_reg !== 3'd5 || wb_regwr !== 1'b1 || wb_err !== 1'b0) begin bad++; $display("FAIL load_wb got=%b/%h/%0d/%b/%b exp=1/beef/5/1/0", wb_valid, wb_data, wb_reg, wb_regwr, wb_err); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL load_noconsume got=%b exp=0", wb_valid); end
  endtask

  task automatic test_store();
    drive_ex(1'b1, 16'h0010, 16'h00AA, 1'b0, 1'b1, 3'd2, 1'b0);
    tick();
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    total++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_wr !== 1'b1 || mem_bus.mem_addr !== 16'h0010 || mem_bus.mem_wdata !== 16'h00AA) begin bad++; $display("FAIL store_bus got=%b/%b/%h/%h exp=1/1/0010/00aa", mem_bus.mem_req, mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_wdata); end
    mem_bus.mem_done = 1'b1;
    tick();
    mem_bus.mem_done = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 16'h0010 || wb_regwr !== 1'b0 || wb_err !== 1'b0 || mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL store_wb got=%b/%h/%b/%b req %b exp=1/0010/0/0 req 0", wb_valid, wb_data, wb_regwr, wb_err, mem_bus.mem_req); end
  endtask

  task automatic test_errors();
    drive_ex(1'b1, 16'h0041, 16'h0000, 1'b1, 1'b0, 3'd4, 1'b1);
    tick();
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    total++; if (mem_bus.mem_req !== 1'b0 || stall_ex !== 1'b0) begin bad++; $display("FAIL misalign_noreq got=%b/%b exp=0/0", mem_bus.mem_req, stall_ex); end
    total++; if (wb_valid !== 1'b1 || wb_err !== 1'b1 || wb_regwr !== 1'b0) begin bad++; $display("FAIL misalign_wb got=%b/%b/%b exp=1/1/0", wb_valid, wb_err, wb_regwr); end
    drive_ex(1'b1, 16'h0042, 16'h0000, 1'b1, 1'b1, 3'd4, 1'b1);
    tick();
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    total++; if (mem_bus.mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_err !== 1'b1 || wb_regwr !== 1'b0) begin bad++; $display("FAIL rdwr_err got=req %b %b/%b/%b exp=req 0 1/1/0", mem_bus.mem_req, wb_valid, wb_err, wb_regwr); end
    // Odd address on a non-memory instruction is just a value, not an error
    drive_ex(1'b1, 16'h0043, 16'h0000, 1'b0, 1'b0, 3'd6, 1'b1);
    tick();
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    total++; if (wb_err !== 1'b0 || wb_data !== 16'h0043 || wb_regwr !== 1'b1) begin bad++; $display("FAIL odd_nonmem got=%b/%h/%b exp=0/0043/1", wb_err, wb_data, wb_regwr); end
  endtask

  task automatic test_timeout();
    int n = 0;
    drive_ex(1'b1, 16'h0080, 16'h0000, 1'b1, 1'b0, 3'd7, 1'b1);
    tick();
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    while (mem_bus.mem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    total++; if (n != MAX_WAIT) begin bad++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, MAX_WAIT); end
    total++; if (wb_valid !== 1'b1 || wb_err !== 1'b1 || wb_regwr !== 1'b0 || stall_ex !== 1'b0) begin bad++; $display("FAIL timeout_wb got=%b/%b/%b stall %b exp=1/1/0 stall 0", wb_valid, wb_err, wb_regwr, stall_ex); end
  endtask

  task automatic test_done_at_limit();
    drive_ex(1'b1, 16'h00A0, 16'h0000, 1'b1, 1'b0, 3'd1, 1'b1);
    tick();
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < MAX_WAIT; i++) begin
      if (i == MAX_WAIT - 1) begin
        mem_bus.mem_done  = 1'b1;
        mem_bus.mem_rdata = 16'hCAFE;
      end
      tick();
    end
    mem_bus.mem_done = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_err !== 1'b0 || wb_data !== 16'hCAFE || wb_regwr !== 1'b1) begin bad++; $display("FAIL done_wins got=%b/%b/%h/%b exp=1/0/cafe/1", wb_valid, wb_err, wb_data, wb_regwr); end
  endtask

  task automatic test_idle_done();
    mem_bus.mem_done  = 1'b1;
    mem_bus.mem_rdata = 16'hDEAD;
    tick();
    tick();
    mem_bus.mem_done = 1'b0;
    total++; if (wb_valid !== 1'b0 || mem_bus.mem_req !== 1'b0 || stall_ex !== 1'b0) begin bad++; $display("FAIL idle_done got=%b/%b/%b exp=0/0/0", wb_valid, mem_bus.mem_req, stall_ex); end
  endtask

  task automatic test_reset_mid();
    drive_ex(1'b1, 16'h0020, 16'h0000, 1'b1, 1'b0, 3'd2, 1'b1);
    tick();
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    total++; if (mem_bus.mem_req !== 1'b1 || stall_ex !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%b/%b exp=1/1", mem_bus.mem_req, stall_ex); end
    #2 rst = 1'b1;
    #1;
    total++; if (mem_bus.mem_req !== 1'b0 || stall_ex !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL rstmid_drop got=%b/%b/%b exp=0/0/0", mem_bus.mem_req, stall_ex, wb_valid); end
    #1 rst = 1'b0;
    drive_ex(1'b1, 16'h5555, 16'h0000, 1'b0, 1'b0, 3'd6, 1'b1);
    tick();
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    total++; if (wb_valid !== 1'b1 || wb_data !== 16'h5555 || wb_reg !== 3'd6) begin bad++; $display("FAIL rstmid_next got=%b/%h/%0d exp=1/5555/6", wb_valid, wb_data, wb_reg); end
  endtask

  task automatic test_back_to_back();
    drive_ex(1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0, 3'd1, 1'b1);
    tick();
    total++; if (wb_valid !== 1'b1 || wb_data !== 16'h0001) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/0001", wb_valid, wb_data); end
    drive_ex(1'b1, 16'h0002, 16'h0000, 1'b0, 1'b0, 3'd2, 1'b0);
    tick();
    drive_ex(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    total++; if (wb_valid !== 1'b1 || wb_data !== 16'h0002 || wb_reg !== 3'd2 || wb_regwr !== 1'b0) begin bad++; $display("FAIL b2b_second got=%b/%h/%0d/%b exp=1/0002/2/0", wb_valid, wb_data, wb_reg, wb_regwr); end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_store();
    test_errors();
    test_timeout();
    test_done_at_limit();
    test_idle_done();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
